// File: rtl/cv32e40p_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_sleep_ctrl
//
// Sleep sequencing controller for the core clock-gating path. Runs on the
// free-running clock and turns a WFI request into an ordered sleep entry:
// drain outstanding activity, gate the core clock, signal sleep. A pending
// interrupt or debug request re-opens the gate and holds a fixed wake-up
// window before control returns to the core.
//
// Ports:
//   clk_ungated_i   free-running clock
//   rst_n           asynchronous active-low reset
//   fetch_enable_i  fetch enable, leaves OFF once seen high
//   wfi_req_i       one-cycle WFI request (honoured in RUN only)
//   busy_i          OR of IF / LSU / APU busy
//   irq_pending_i   enabled interrupt pending (level)
//   debug_req_i     debug request (level)
//   cnt_clr_i       synchronous clear of sleep_cycles_o
//   clock_en_o      enable of the core main clock gate
//   core_sleep_o    core is asleep
//   sleep_ack_o     pulse: sleep entered
//   abort_o         pulse: WFI ended without sleeping
//   wake_o          pulse: wake-up window complete
//   sleep_cycles_o  saturating count of idle SLEEP cycles
// -----------------------------------------------------------------------------
module cv32e40p_sleep_ctrl #(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int WAKE_DELAY    = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk_ungated_i,
  input  logic             rst_n,
  input  logic             fetch_enable_i,
  input  logic             wfi_req_i,
  input  logic             busy_i,
  input  logic             irq_pending_i,
  input  logic             debug_req_i,
  input  logic             cnt_clr_i,
  output logic             clock_en_o,
  output logic             core_sleep_o,
  output logic             sleep_ack_o,
  output logic             abort_o,
  output logic             wake_o,
  output logic [CNT_W-1:0] sleep_cycles_o
);

  // One timer serves both the drain budget and the wake-up window, so it is
  // sized for the larger of the two.
  localparam int TMR_MAX = (DRAIN_TIMEOUT > WAKE_DELAY) ? DRAIN_TIMEOUT : WAKE_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] WAKE_LOAD  = TMR_W'(WAKE_DELAY - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_SLEEP = 3'd3;
  localparam logic [2:0] S_WAKE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             wake_ev;

  assign wake_ev = irq_pending_i | debug_req_i;

  // Next-state and Mealy outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    tmr_d        = tmr_q;
    clock_en_o   = 1'b0;
    core_sleep_o = 1'b0;
    sleep_ack_o  = 1'b0;
    abort_o      = 1'b0;
    wake_o       = 1'b0;

    case (state_q)
      S_OFF: begin
        if (fetch_enable_i) state_d = S_RUN;
      end

      S_RUN: begin
        clock_en_o = 1'b1;
        if (wfi_req_i) begin
          if (wake_ev) begin
            // A wake source is already pending: the WFI degenerates to a NOP.
            abort_o = 1'b1;
          end else begin
            state_d = S_DRAIN;
            tmr_d   = DRAIN_LOAD;
          end
        end
      end

      S_DRAIN: begin
        clock_en_o = 1'b1;
        // A wake event outranks a completed drain, so the core never gates
        // its clock while an interrupt or debug request is waiting.
        if (wake_ev) begin
          abort_o = 1'b1;
          state_d = S_RUN;
        end else if (!busy_i) begin
          sleep_ack_o = 1'b1;
          state_d     = S_SLEEP;
        end else if (tmr_q == '0) begin
          abort_o = 1'b1;
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      S_SLEEP: begin
        // Combinational so the gate opens in the very cycle the event shows.
        clock_en_o   = wake_ev;
        core_sleep_o = !wake_ev;
        if (wake_ev) begin
          state_d = S_WAKE;
          tmr_d   = WAKE_LOAD;
        end
      end

      S_WAKE: begin
        clock_en_o = 1'b1;
        // The window runs to completion even if the wake source drops.
        if (tmr_q == '0) begin
          wake_o  = 1'b1;
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end

      default: begin
        state_d = S_OFF;
        tmr_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Idle-sleep statistics; clear wins over increment, and the count sticks
  // at all-ones instead of wrapping.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      sleep_cycles_o <= '0;
    end else if (cnt_clr_i) begin
      sleep_cycles_o <= '0;
    end else if (state_q == S_SLEEP && !wake_ev && sleep_cycles_o != '1) begin
      sleep_cycles_o <= sleep_cycles_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_sleep_ctrl
//
// Scenario bench for cv32e40p_sleep_ctrl (DRAIN_TIMEOUT=16, WAKE_DELAY=2,
// CNT_W=4). Each task drives one scenario; expected outputs come from the
// timing rules of the controller (cycle offsets of ack/abort/wake, saturating
// arithmetic for the counter). Outputs are packed as
// {clock_en, core_sleep, sleep_ack, abort, wake}.
// -----------------------------------------------------------------------------
module tb_cv32e40p_sleep_ctrl;

  localparam int DT = 16;
  localparam int WD = 2;
  localparam int CW = 4;

  logic          clk_ungated_i = 1'b0;
  logic          rst_n;
  logic          fetch_enable_i, wfi_req_i, busy_i, irq_pending_i, debug_req_i, cnt_clr_i;
  logic          clock_en_o, core_sleep_o, sleep_ack_o, abort_o, wake_o;
  logic [CW-1:0] sleep_cycles_o;
  logic [4:0]    outs;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt;

  localparam logic [4:0] O_OFF   = 5'b00000;
  localparam logic [4:0] O_RUN   = 5'b10000;
  localparam logic [4:0] O_SLP   = 5'b01000;
  localparam logic [4:0] O_ACK   = 5'b10100;
  localparam logic [4:0] O_ABORT = 5'b10010;
  localparam logic [4:0] O_WAKE  = 5'b10001;

  assign outs = {clock_en_o, core_sleep_o, sleep_ack_o, abort_o, wake_o};

  always #5 clk_ungated_i = ~clk_ungated_i;

  cv32e40p_sleep_ctrl #(
    .DRAIN_TIMEOUT(DT),
    .WAKE_DELAY   (WD),
    .CNT_W        (CW)
  ) dut (
    .clk_ungated_i (clk_ungated_i),
    .rst_n         (rst_n),
    .fetch_enable_i(fetch_enable_i),
    .wfi_req_i     (wfi_req_i),
    .busy_i        (busy_i),
    .irq_pending_i (irq_pending_i),
    .debug_req_i   (debug_req_i),
    .cnt_clr_i     (cnt_clr_i),
    .clock_en_o    (clock_en_o),
    .core_sleep_o  (core_sleep_o),
    .sleep_ack_o   (sleep_ack_o),
    .abort_o       (abort_o),
    .wake_o        (wake_o),
    .sleep_cycles_o(sleep_cycles_o)
  );

  // Advance into the next cycle; inputs are changed here and outputs are
  // sampled #1 later, well away from the clock edge.
  task automatic step();
    @(posedge clk_ungated_i);
    #1;
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    {fetch_enable_i, wfi_req_i, busy_i, irq_pending_i, debug_req_i, cnt_clr_i} = '0;
    #3;
    if (outs !== O_OFF) begin $display("FAIL reset_outs got=%b exp=%b", outs, O_OFF); errors++; end
    checks++;
    if (sleep_cycles_o !== '0) begin $display("FAIL reset_cnt got=%0d exp=0", sleep_cycles_o); errors++; end
    checks++;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      if (outs !== O_OFF) begin $display("FAIL off_hold[%0d] got=%b exp=%b", i, outs, O_OFF); errors++; end
      checks++;
    end
    exp_cnt = '0;
  endtask

  task automatic test_boot();
    step(); fetch_enable_i = 1'b1; #1;
    if (outs !== O_OFF) begin $display("FAIL boot_same_cycle got=%b exp=%b", outs, O_OFF); errors++; end
    checks++;
    step(); fetch_enable_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL boot_run got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (outs !== O_RUN) begin $display("FAIL boot_sticky[%0d] got=%b exp=%b", i, outs, O_RUN); errors++; end
      checks++;
    end
  endtask

  // From RUN: WFI with nothing busy, ack in the first DRAIN cycle, SLEEP next.
  task automatic enter_sleep(input string tag);
    step(); wfi_req_i = 1'b1; busy_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL %s_wfi got=%b exp=%b", tag, outs, O_RUN); errors++; end
    checks++;
    step(); wfi_req_i = 1'b0; #1;
    if (outs !== O_ACK) begin $display("FAIL %s_ack got=%b exp=%b", tag, outs, O_ACK); errors++; end
    checks++;
  endtask

  // SLEEP cycle with a wake event, then the WAKE window, then one RUN cycle.
  task automatic wake_up(input string tag, input logic dbg);
    step(); irq_pending_i = !dbg; debug_req_i = dbg; #1;
    if (outs !== O_RUN) begin $display("FAIL %s_gate_open got=%b exp=%b", tag, outs, O_RUN); errors++; end
    checks++;
    for (int k = 1; k <= WD; k++) begin
      step(); irq_pending_i = 1'b0; debug_req_i = 1'b0; #1;
      if (outs !== ((k == WD) ? O_WAKE : O_RUN)) begin
        $display("FAIL %s_wake[%0d] got=%b exp=%b", tag, k, outs, (k == WD) ? O_WAKE : O_RUN); errors++;
      end
      checks++;
    end
    step(); #1;
    if (outs !== O_RUN) begin $display("FAIL %s_back_run got=%b exp=%b", tag, outs, O_RUN); errors++; end
    checks++;
  endtask

  task automatic test_clean_sleep();
    enter_sleep("clean");
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      if (outs !== O_SLP) begin $display("FAIL clean_sleep[%0d] got=%b exp=%b", i, outs, O_SLP); errors++; end
      checks++;
      exp_cnt = sat_inc(exp_cnt);
    end
    step(); irq_pending_i = 1'b1; #1;
    if (outs !== O_RUN) begin $display("FAIL clean_irq_gate got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    if (sleep_cycles_o !== 4'd10) begin $display("FAIL clean_cnt got=%0d exp=10", sleep_cycles_o); errors++; end
    checks++;
    step(); #1;
    if (outs !== O_RUN) begin $display("FAIL clean_wake1 got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    step(); #1;
    if (outs !== O_WAKE) begin $display("FAIL clean_wake2 got=%b exp=%b", outs, O_WAKE); errors++; end
    checks++;
    step(); irq_pending_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL clean_run got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
  endtask

  task automatic test_drain_timeout();
    step(); wfi_req_i = 1'b1; busy_i = 1'b1; #1;
    if (outs !== O_RUN) begin $display("FAIL tmo_wfi got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    for (int i = 1; i <= DT; i++) begin
      step(); wfi_req_i = 1'b0; #1;
      if (outs !== ((i == DT) ? O_ABORT : O_RUN)) begin
        $display("FAIL tmo_drain[%0d] got=%b exp=%b", i, outs, (i == DT) ? O_ABORT : O_RUN); errors++;
      end
      checks++;
    end
    step(); busy_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL tmo_run got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    if (sleep_cycles_o !== exp_cnt) begin $display("FAIL tmo_cnt got=%0d exp=%0d", sleep_cycles_o, exp_cnt); errors++; end
    checks++;
  endtask

  task automatic test_abort();
    // WFI with debug pending: NOP in RUN.
    step(); wfi_req_i = 1'b1; debug_req_i = 1'b1; #1;
    if (outs !== O_ABORT) begin $display("FAIL nop_abort got=%b exp=%b", outs, O_ABORT); errors++; end
    checks++;
    step(); wfi_req_i = 1'b0; debug_req_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL nop_run got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    // Still in RUN: a fresh WFI acks one cycle later.
    enter_sleep("nop_after");
    wake_up("nop_after", 1'b1);
    // irq rises and busy falls in the same DRAIN cycle: abort wins.
    step(); wfi_req_i = 1'b1; busy_i = 1'b1; #1;
    step(); wfi_req_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL simul_drain1 got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    step(); irq_pending_i = 1'b1; busy_i = 1'b0; #1;
    if (outs !== O_ABORT) begin $display("FAIL simul_abort got=%b exp=%b", outs, O_ABORT); errors++; end
    checks++;
    step(); irq_pending_i = 1'b0; #1;
    if (outs !== O_RUN) begin $display("FAIL simul_run got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
  endtask

  task automatic test_counter();
    step(); cnt_clr_i = 1'b1; #1;
    step(); cnt_clr_i = 1'b0; #1;
    if (sleep_cycles_o !== '0) begin $display("FAIL cnt_clr_run got=%0d exp=0", sleep_cycles_o); errors++; end
    checks++;
    exp_cnt = '0;
    enter_sleep("sat");
    for (int i = 0; i < 20; i++) begin
      // wfi_req_i toggles freely: it must be ignored outside RUN.
      step(); wfi_req_i = 1'($urandom_range(0, 1)); #1;
      if (outs !== O_SLP) begin $display("FAIL sat_sleep[%0d] got=%b exp=%b", i, outs, O_SLP); errors++; end
      checks++;
      if (sleep_cycles_o !== exp_cnt) begin $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, sleep_cycles_o, exp_cnt); errors++; end
      checks++;
      exp_cnt = sat_inc(exp_cnt);
    end
    step(); wfi_req_i = 1'b0; cnt_clr_i = 1'b1; #1;
    if (sleep_cycles_o !== 4'd15) begin $display("FAIL sat_value got=%0d exp=15", sleep_cycles_o); errors++; end
    checks++;
    step(); cnt_clr_i = 1'b0; #1;
    if (sleep_cycles_o !== '0) begin $display("FAIL clr_in_sleep got=%0d exp=0", sleep_cycles_o); errors++; end
    checks++;
    step(); #1;
    if (sleep_cycles_o !== 4'd1) begin $display("FAIL cnt_after_clr got=%0d exp=1", sleep_cycles_o); errors++; end
    checks++;
  endtask

  // Entered from SLEEP (left there by test_counter).
  task automatic test_reset_mid();
    step(); irq_pending_i = 1'b1; #1;
    step(); #1;
    if (outs !== O_RUN) begin $display("FAIL mid_in_wake got=%b exp=%b", outs, O_RUN); errors++; end
    checks++;
    rst_n = 1'b0; #1;
    if (outs !== O_OFF) begin $display("FAIL mid_reset_outs got=%b exp=%b", outs, O_OFF); errors++; end
    checks++;
    if (sleep_cycles_o !== '0) begin $display("FAIL mid_reset_cnt got=%0d exp=0", sleep_cycles_o); errors++; end
    checks++;
    step(); rst_n = 1'b1; irq_pending_i = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (outs !== O_OFF) begin $display("FAIL mid_off[%0d] got=%b exp=%b", i, outs, O_OFF); errors++; end
      checks++;
    end
    exp_cnt = '0;
    test_boot();
  endtask

  // Random WFI episodes. w = DRAIN cycle where a wake source appears (0: in
  // the WFI cycle itself), b = DRAIN cycle where busy first drops. The
  // episode ends at the earliest of wake, idle, or the drain budget.
  task automatic test_random();
    int w, b, end_c, s;
    logic slept, clr;
    for (int it = 0; it < 40; it++) begin
      w = $urandom_range(0, 22);
      b = $urandom_range(1, 20);
      if (w == 0) begin
        step(); wfi_req_i = 1'b1; {irq_pending_i, debug_req_i} = 2'($urandom_range(1, 3)); #1;
        if (outs !== O_ABORT) begin $display("FAIL rnd%0d_nop got=%b exp=%b", it, outs, O_ABORT); errors++; end
        checks++;
      end else begin
        if (w <= b && w <= DT)  begin end_c = w;  slept = 1'b0; end
        else if (b <= DT)       begin end_c = b;  slept = 1'b1; end
        else                    begin end_c = DT; slept = 1'b0; end
        step(); wfi_req_i = 1'b1; busy_i = 1'b1; #1;
        for (int d = 1; d <= end_c; d++) begin
          step();
          wfi_req_i = 1'b0;
          busy_i    = (d < b);
          if (d >= w) {irq_pending_i, debug_req_i} = 2'($urandom_range(1, 3));
          else        {irq_pending_i, debug_req_i} = 2'b00;
          #1;
          if (outs !== ((d == end_c) ? (slept ? O_ACK : O_ABORT) : O_RUN)) begin
            $display("FAIL rnd%0d_drain[%0d] got=%b exp=%b", it, d, outs,
                     (d == end_c) ? (slept ? O_ACK : O_ABORT) : O_RUN);
            errors++;
          end
          checks++;
        end
        if (slept) begin
          s = $urandom_range(0, 5);
          for (int i = 0; i < s; i++) begin
            step(); busy_i = 1'($urandom_range(0, 1)); clr = ($urandom_range(0, 5) == 0); cnt_clr_i = clr; #1;
            if (outs !== O_SLP) begin $display("FAIL rnd%0d_sleep[%0d] got=%b exp=%b", it, i, outs, O_SLP); errors++; end
            checks++;
            if (sleep_cycles_o !== exp_cnt) begin
              $display("FAIL rnd%0d_cnt[%0d] got=%0d exp=%0d", it, i, sleep_cycles_o, exp_cnt); errors++;
            end
            checks++;
            exp_cnt = clr ? '0 : sat_inc(exp_cnt);
          end
          step(); cnt_clr_i = 1'b0; {irq_pending_i, debug_req_i} = 2'($urandom_range(1, 3)); #1;
          if (outs !== O_RUN) begin $display("FAIL rnd%0d_gate got=%b exp=%b", it, outs, O_RUN); errors++; end
          checks++;
          for (int k = 1; k <= WD; k++) begin
            step(); {irq_pending_i, debug_req_i} = 2'($urandom_range(0, 3)); #1;
            if (outs !== ((k == WD) ? O_WAKE : O_RUN)) begin
              $display("FAIL rnd%0d_wake[%0d] got=%b exp=%b", it, k, outs, (k == WD) ? O_WAKE : O_RUN); errors++;
            end
            checks++;
          end
        end
      end
      step(); {wfi_req_i, busy_i, irq_pending_i, debug_req_i, cnt_clr_i} = '0; #1;
      if (outs !== O_RUN) begin $display("FAIL rnd%0d_run got=%b exp=%b", it, outs, O_RUN); errors++; end
      checks++;
      if (sleep_cycles_o !== exp_cnt) begin $display("FAIL rnd%0d_cnt_end got=%0d exp=%0d", it, sleep_cycles_o, exp_cnt); errors++; end
      checks++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot();
    test_clean_sleep();
    test_drain_timeout();
    test_abort();
    test_counter();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
